// File: rtl/mul_lod_norm_pipe.sv
// mul_lod_norm_pipe
//   Pipelined leading-one detector and left normaliser for the multiplier's
//   post-product normalisation path. Counts leading zeros of a WIDTH-bit word
//   and shifts the word left so its MSB is 1. An all-zero word is flagged.
//   A valid/ready handshake with full backpressure is used on both sides.
//
//   Optional feature macro: MUL_LOD_MAXSHIFT_EN
//     When this macro is defined, the max_shift input and the out_clamp output
//     exist. The shift is limited to max_shift, and out_clamp reports that the
//     limit was hit.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data, in_tag     word to normalise and its sideband tag
//   out_valid/out_ready output handshake
//   out_norm            in_data << out_lz, zero-filled from the right
//   out_lz              shift amount applied (WIDTH for an all-zero word)
//   out_zero            in_data was all zeros
//   out_tag             tag travelling with the word
//   max_shift           shift limit, sampled with in_data (macro only)
//   out_clamp           shift was limited by max_shift (macro only)
module mul_lod_norm_pipe #(
  parameter int WIDTH       = 24,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_norm,
  output logic [CW-1:0]    out_lz,
  output logic             out_zero,
`ifdef MUL_LOD_MAXSHIFT_EN
  input  logic [CW-1:0]    max_shift,
  output logic             out_clamp,
`endif
  output logic [TAG_W-1:0] out_tag
);

  // This mask selects the top 2^k bits of the word. When 2^k >= WIDTH, the
  // mask covers the whole word. The remaining-width test then skips that level.
  function automatic logic [WIDTH-1:0] top_mask(input int k);
    top_mask = ~({WIDTH{1'b1}} >> (1 << k));
  endfunction

  logic [PIPE_STAGES-1:0] v_vec;
  logic [PIPE_STAGES:0]   rdy;

  // Ready chain. A stage can load when it is empty or when its contents move
  // on in the same cycle. Evaluating from the output back lets bubbles collapse.
  always_comb begin
    rdy              = '0;
    rdy[PIPE_STAGES] = out_ready;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
      rdy[s] = !v_vec[s] || rdy[s+1];
    end
  end

  assign in_ready = rdy[0];

  genvar gi;
  for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [CW-1:0]    src_lz;
    logic             src_zero;
    logic [TAG_W-1:0] src_tag;
    logic [WIDTH-1:0] data_next;
    logic [CW-1:0]    lz_next;
    logic             v_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CW-1:0]    lz_reg;
    logic             zero_reg;
    logic [TAG_W-1:0] tag_reg;
    int               lim;
`ifdef MUL_LOD_MAXSHIFT_EN
    logic [CW-1:0]    src_ms;
`endif

    if (gi == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_lz    = '0;
      assign src_zero  = ~|in_data;
      assign src_tag   = in_tag;
`ifdef MUL_LOD_MAXSHIFT_EN
      assign src_ms    = max_shift;
`endif
    end else begin : g_src
      assign src_valid = g_stage[gi-1].v_reg;
      assign src_data  = g_stage[gi-1].data_reg;
      assign src_lz    = g_stage[gi-1].lz_reg;
      assign src_zero  = g_stage[gi-1].zero_reg;
      assign src_tag   = g_stage[gi-1].tag_reg;
`ifdef MUL_LOD_MAXSHIFT_EN
      assign src_ms    = g_stage[gi-1].g_ms.ms_reg;
`endif
    end

    // This stage applies only the shift levels assigned to it, largest first.
    // A level is taken only when the bits it tests are all zero and the
    // running count stays within the limit (WIDTH, or max_shift if lower).
    // Taking levels greedily in this way gives min(true_lz, limit) exactly.
    always_comb begin
      data_next = src_data;
      lz_next   = src_lz;
      lim       = WIDTH;
`ifdef MUL_LOD_MAXSHIFT_EN
      if (int'(src_ms) < lim) lim = int'(src_ms);
`endif
      for (int k = CW - 1; k >= 0; k--) begin
        if ((((CW - 1 - k) * PIPE_STAGES) / CW) == gi) begin
          if (((data_next & top_mask(k)) == '0) &&
              ((int'(lz_next) + (1 << k)) <= lim)) begin
            data_next = data_next << (1 << k);
            lz_next   = lz_next | CW'(1 << k);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg    <= 1'b0;
        data_reg <= '0;
        lz_reg   <= '0;
        zero_reg <= 1'b0;
        tag_reg  <= '0;
      end else if (rdy[gi]) begin
        v_reg <= src_valid;
        if (src_valid) begin
          data_reg <= data_next;
          lz_reg   <= lz_next;
          zero_reg <= src_zero;
          tag_reg  <= src_tag;
        end
      end
    end

    assign v_vec[gi] = v_reg;

`ifdef MUL_LOD_MAXSHIFT_EN
    // The limit travels with its word to every stage except the last.
    if (gi < PIPE_STAGES - 1) begin : g_ms
      logic [CW-1:0] ms_reg;
      always_ff @(posedge clk) begin
        if (rst) ms_reg <= '0;
        else if (rdy[gi] && src_valid) ms_reg <= src_ms;
      end
    end

    // After the final level, a clear MSB with a count below WIDTH means the
    // limit stopped the shift early. This holds for a zero word as well.
    if (gi == PIPE_STAGES - 1) begin : g_clamp
      logic clamp_reg;
      always_ff @(posedge clk) begin
        if (rst) clamp_reg <= 1'b0;
        else if (rdy[gi] && src_valid)
          clamp_reg <= !data_next[WIDTH-1] && (int'(lz_next) < WIDTH);
      end
    end
`endif
  end

  assign out_valid = g_stage[PIPE_STAGES-1].v_reg;
  assign out_norm  = g_stage[PIPE_STAGES-1].data_reg;
  assign out_lz    = g_stage[PIPE_STAGES-1].lz_reg;
  assign out_zero  = g_stage[PIPE_STAGES-1].zero_reg;
  assign out_tag   = g_stage[PIPE_STAGES-1].tag_reg;
`ifdef MUL_LOD_MAXSHIFT_EN
  assign out_clamp = g_stage[PIPE_STAGES-1].g_clamp.clamp_reg;
`endif

endmodule
